fp_minmax_reduce: RTL

//  Streaming FP32 min/max reduction stage that sits directly downstream of the floating ALU operand path.

---
 rtl/fp_minmax_reduce.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fp_minmax_reduce.sv
// Streaming FP32 min/max reduction with RISC-V FMIN.S/FMAX.S NaN and signed-zero semantics.
// One registered {min, max, count, nv} result per in_last-terminated vector.
module fp_minmax_reduce #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_min,
    output logic [XLEN-1:0]  out_max,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nv
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

    localparam logic [XLEN-1:0] CANON_NAN = 32'h7FC00000;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  min_q, min_d;
    logic [XLEN-1:0]  max_q, max_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             nv_q, nv_d;
    logic             accept;

    function automatic logic is_nan(input logic [XLEN-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != '0);
    endfunction

    function automatic logic is_snan(input logic [XLEN-1:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic logic [XLEN-1:0] canon(input logic [XLEN-1:0] x);
        return is_nan(x) ? CANON_NAN : x;
    endfunction

    // Monotonic unsigned key: -0 sorts below +0, infinities at the ends.
    function automatic logic [XLEN-1:0] order_key(input logic [XLEN-1:0] x);
        return x[31] ? ~x : (x | 32'h80000000);
    endfunction

    // a is the stored value; on equal keys it is retained.
    function automatic logic [XLEN-1:0] fmin(input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
        logic a_nan;
        logic b_nan;
        a_nan = is_nan(a);
        b_nan = is_nan(b);
        if (a_nan && b_nan) begin
            return CANON_NAN;
        end else if (a_nan) begin
            return b;
        end else if (b_nan) begin
            return a;
        end else begin
            return (order_key(b) < order_key(a)) ? b : a;
        end
    endfunction

    function automatic logic [XLEN-1:0] fmax(input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
        logic a_nan;
        logic b_nan;
        a_nan = is_nan(a);
        b_nan = is_nan(b);
        if (a_nan && b_nan) begin
            return CANON_NAN;
        end else if (a_nan) begin
            return b;
        end else if (b_nan) begin
            return a;
        end else begin
            return (order_key(b) > order_key(a)) ? b : a;
        end
    endfunction

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;
    assign out_nv    = nv_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        nv_d    = nv_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    min_d   = canon(in_data);
                    max_d   = canon(in_data);
                    count_d = CNT_W'(1);
                    nv_d    = is_snan(in_data);
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    min_d   = fmin(min_q, in_data);
                    max_d   = fmax(max_q, in_data);
                    count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    nv_d    = nv_q | is_snan(in_data);
                    if (in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Results stay on the outputs after leaving DONE until the next first accept.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            nv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
            nv_q    <= nv_d;
        end
    end

endmodule
